// File: rtl/chargen_ctrl.sv
// chargen_ctrl: RFC 864 character-generator sequencer.
// Emits rotating lines of LINE_LEN printable characters (0x20..0x7E), each
// terminated by CR LF, into a FIFO write port, honouring fifo_full.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mode       00 stop, 01 continuous, 10 single line per start, 11 = 00
//   start      one-line trigger (IDLE with mode 10 only)
//   fifo_full  FIFO full flag; stalls the sequencer
//   fifo_wr    write strobe (combinational)
//   fifo_wdata write data (combinational), 0x00 in IDLE
//   busy       high whenever not IDLE
//   line_done  one-cycle pulse the cycle after LF is accepted
module chargen_ctrl #(
  parameter int unsigned LINE_LEN = 72
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       start,
  input  logic       fifo_full,
  output logic       fifo_wr,
  output logic [7:0] fifo_wdata,
  output logic       busy,
  output logic       line_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHAR,
    S_CR,
    S_LF
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(LINE_LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] line_start_q, line_start_d;
  logic [7:0] cur_char_q, cur_char_d;
  logic [7:0] char_idx_q, char_idx_d;
  logic       line_done_q, line_done_d;

  function automatic logic [7:0] next_char(input logic [7:0] c);
    return (c == 8'h7E) ? 8'h20 : c + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      line_start_q <= 8'h21;
      cur_char_q   <= 8'h21;
      char_idx_q   <= '0;
      line_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_start_q <= line_start_d;
      cur_char_q   <= cur_char_d;
      char_idx_q   <= char_idx_d;
      line_done_q  <= line_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    line_start_d = line_start_q;
    cur_char_d   = cur_char_q;
    char_idx_d   = char_idx_q;
    line_done_d  = 1'b0;
    fifo_wr      = (state_q != S_IDLE) && !fifo_full;
    fifo_wdata   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (mode == 2'b01 || (mode == 2'b10 && start)) begin
          state_d    = S_CHAR;
          cur_char_d = line_start_q;
          char_idx_d = '0;
        end
      end
      S_CHAR: begin
        fifo_wdata = cur_char_q;
        if (fifo_wr) begin
          cur_char_d = next_char(cur_char_q);
          char_idx_d = char_idx_q + 8'd1;
          if (char_idx_q == LAST_IDX) state_d = S_CR;
        end
      end
      S_CR: begin
        fifo_wdata = 8'h0D;
        if (fifo_wr) state_d = S_LF;
      end
      S_LF: begin
        fifo_wdata = 8'h0A;
        if (fifo_wr) begin
          line_start_d = next_char(line_start_q);
          line_done_d  = 1'b1;
          // Continuous mode chains straight into the next line so there is
          // no idle cycle between lines; start is deliberately not looked at.
          if (mode == 2'b01) begin
            state_d    = S_CHAR;
            cur_char_d = next_char(line_start_q);
            char_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign line_done = line_done_q;

endmodule

// File: tb/tb_chargen_ctrl.sv
// Scoreboard bench for chargen_ctrl (LINE_LEN = 4). Expected bytes are
// computed from the line number: character j of line k (counted from reset)
// is 0x20 + ((1 + k + j) mod 95).
module tb_chargen_ctrl;

  localparam int unsigned LL    = 4;
  localparam int unsigned BOUND = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b01;
  logic       start = 1'b0;
  logic       fifo_full = 1'b0;
  logic       fifo_wr;
  logic [7:0] fifo_wdata;
  logic       busy;
  logic       line_done;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  q[$];
  int unsigned line_no = 0;
  logic        lf_prev = 1'b0;

  chargen_ctrl #(.LINE_LEN(LL)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .start      (start),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .busy       (busy),
    .line_done  (line_done)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void push_line(input int unsigned k);
    for (int unsigned j = 0; j < LL; j++) q.push_back(8'(32'h20 + (1 + k + j) % 95));
    q.push_back(8'h0D);
    q.push_back(8'h0A);
  endfunction

  function automatic void push_lines(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      push_line(line_no);
      line_no++;
    end
  endfunction

  // Monitor: pops one expected byte per accepted write, checks stalls and
  // the line_done pulse that must follow every accepted LF.
  initial begin
    forever begin
      @(negedge clk);
      chk("line_done", {7'd0, line_done}, {7'd0, lf_prev});
      if (fifo_full === 1'b1) begin
        chk("wr_while_full", {7'd0, fifo_wr}, 8'h00);
        if (busy === 1'b1 && q.size() > 0) chk("held_data", fifo_wdata, q[0]);
      end else if (fifo_wr === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_write got %h expected no write at %0t", fifo_wdata, $time);
        end else begin
          chk("stream", fifo_wdata, q.pop_front());
        end
      end
      lf_prev = (fifo_wr === 1'b1) && (fifo_wdata == 8'h0A) && (fifo_full === 1'b0)
                && (rst === 1'b0);
    end
  end

  // Entered at time 0 or just after a posedge; leaves at a negedge with rst low.
  task automatic do_reset(input logic [1:0] m);
    rst = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_wr", {7'd0, fifo_wr}, 8'h00);
      chk("rst_wdata", fifo_wdata, 8'h00);
      chk("rst_busy", {7'd0, busy}, 8'h00);
      chk("rst_line_done", {7'd0, line_done}, 8'h00);
    end
    q.delete();
    line_no = 0;
    mode = m;
    rst = 1'b0;
  endtask

  task automatic drain(input bit rbp);
    int unsigned n = 0;
    while (q.size() != 0 && n < BOUND) begin
      if (rbp) fifo_full = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 8'(q.size()), 8'h00);
      q.delete();
    end
    fifo_full = 1'b0;
    @(negedge clk);
    chk("idle_busy", {7'd0, busy}, 8'h00);
    chk("idle_wr", {7'd0, fifo_wr}, 8'h00);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Drops mode to 00 once two characters of the last queued line are out.
  task automatic stop_cont(input bit rbp);
    int unsigned n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() <= 4) break;
      if (rbp) fifo_full = ($urandom_range(0, 3) == 0);
      n++;
      if (n > BOUND) begin
        chk("stop_timeout", 8'(q.size()), 8'h04);
        break;
      end
    end
    mode = 2'b00;
    drain(rbp);
  endtask

  task automatic wait_size(input int unsigned s, input string nm);
    int unsigned n = 0;
    while (q.size() != s && n < BOUND) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != s) chk(nm, 8'(q.size()), 8'(s));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    // Reset, first-write latency, continuous stream without gaps
    do_reset(2'b01);
    push_lines(3);
    @(negedge clk);
    chk("first_wr", {7'd0, fifo_wr}, 8'h01);
    chk("first_data", fifo_wdata, 8'h21);
    for (int unsigned i = 0; i < 11; i++) begin
      @(negedge clk);
      chk("no_gap", {7'd0, fifo_wr}, 8'h01);
    end
    stop_cont(1'b0);

    // Backpressure while 0x23 is presented
    @(posedge clk);
    #1;
    do_reset(2'b01);
    push_lines(2);
    wait_size(10, "wait_23");
    chk("front_23", q[0], 8'h23);
    fifo_full = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_wr", {7'd0, fifo_wr}, 8'h00);
      chk("bp_data", fifo_wdata, 8'h23);
      @(posedge clk);
      #1;
    end
    fifo_full = 1'b0;
    stop_cont(1'b0);

    // Single line per start, mid-line start ignored
    do_reset(2'b00);
    repeat (2) @(posedge clk);
    #1;
    mode = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    push_lines(1);
    pulse_start();
    wait_size(3, "single_mid");
    pulse_start();
    drain(1'b0);
    push_lines(1);
    pulse_start();
    drain(1'b0);

    // Reset in the middle of a continuous line
    mode = 2'b01;
    push_lines(2);
    wait_size(9, "midline_rst");
    do_reset(2'b01);
    push_lines(2);
    @(negedge clk);
    chk("restart_wr", {7'd0, fifo_wr}, 8'h01);
    chk("restart_data", fifo_wdata, 8'h21);
    stop_cont(1'b0);

    // Long continuous run through the 0x7E -> 0x20 wrap, random backpressure
    push_lines(95);
    mode = 2'b01;
    stop_cont(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
